// File: rtl/lfsr_chk_if.sv
// Sample/statistics bundle for lfsr_chk. The bit_cnt signal exists only when
// LFSR_CHK_BITCNT_EN is defined.
interface lfsr_chk_if #(
    parameter int unsigned CNT_W = 16
);
    logic             enb;
    logic             din;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;

    modport master (output enb, din, clr_cnt, input locked, err, err_cnt, bit_cnt);
    modport slave  (input enb, din, clr_cnt, output locked, err, err_cnt, bit_cnt);
`else
    modport master (output enb, din, clr_cnt, input locked, err, err_cnt);
    modport slave  (input enb, din, clr_cnt, output locked, err, err_cnt);
`endif
endinterface

// File: rtl/lfsr_chk.sv
// Self-synchronising checker for the period-15 LFSR stream with BER counters.
// Define LFSR_CHK_BITCNT_EN to add the checked-bit counter (bit_cnt).
module lfsr_chk #(
    parameter int unsigned SYNC_LEN = 8,
    parameter int unsigned LOSS_LEN = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lfsr_chk_if.slave bus
);
    localparam logic StHunt = 1'b0;
    localparam logic StLock = 1'b1;

    localparam logic [3:0] SyncLen = 4'(SYNC_LEN);
    localparam logic [3:0] LossLen = 4'(LOSS_LEN);

    logic             state_q, state_d;
    logic [3:0]       hist_q, hist_d;
    logic [2:0]       fill_q, fill_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pred;
    logic             new_bit;
    logic             hit;
    logic             miss;

    // hist[0] is the oldest bit: b(n+4) = b(n+1) ^ b(n)
    assign pred = hist_q[1] ^ hist_q[0];

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        new_bit   = pred;
        hit       = 1'b0;
        miss      = 1'b0;

        if (bus.enb) begin
            if (state_q == StHunt) begin
                new_bit = bus.din;
                if (fill_q != 3'd4) begin
                    fill_d = fill_q + 3'd1;
                end else begin
                    // All-zero history is the LFSR lock-up state and never counts as a match
                    hit = (bus.din == pred) && (hist_q != 4'd0);
                    if (hit) begin
                        match_d = match_q + 4'd1;
                        if (match_d == SyncLen) begin
                            state_d = StLock;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
            end else begin
                // Reference free-runs in LOCK so a bad input bit cannot poison later predictions
                miss = (bus.din != pred);
                if (miss) begin
                    err_d  = 1'b1;
                    miss_d = miss_q + 4'd1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (miss_d == LossLen) begin
                        state_d = StHunt;
                        fill_d  = 3'd0;
                        match_d = 4'd0;
                        miss_d  = 4'd0;
                    end
                end else begin
                    miss_d = 4'd0;
                end
            end
            hist_d = {new_bit, hist_q[3:1]};
        end

        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StHunt;
            hist_q    <= 4'd0;
            fill_q    <= 3'd0;
            match_q   <= 4'd0;
            miss_q    <= 4'd0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.locked  = (state_q == StLock);
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (bus.enb && (state_q == StLock) && (bit_cnt_q != '1)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (bus.clr_cnt) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.bit_cnt = bit_cnt_q;
`endif
endmodule

// File: tb/tb_lfsr_chk.sv
// Directed plus randomized bench for lfsr_chk; two instances (default config and
// CNT_W=4/LOSS_LEN=15) share one stimulus stream and are checked against a reference model.
module tb_lfsr_chk;
    logic clk = 1'b0;
    logic rst_n;
    logic en, d, clr;

    always #5 clk = ~clk;

    lfsr_chk_if #(.CNT_W(16)) bus_a ();
    lfsr_chk_if #(.CNT_W(4))  bus_b ();

    assign bus_a.enb     = en;
    assign bus_a.din     = d;
    assign bus_a.clr_cnt = clr;
    assign bus_b.enb     = en;
    assign bus_b.din     = d;
    assign bus_b.clr_cnt = clr;

    lfsr_chk #(.SYNC_LEN(8), .LOSS_LEN(3), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    lfsr_chk #(.SYNC_LEN(8), .LOSS_LEN(15), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        bit       lk;
        int       fill;
        int       match;
        int       miss;
        int       ecnt;
        int       bcnt;
        bit       err;
        bit [3:0] age;   // age[0] newest sample, age[3] oldest
    } mdl_t;

    int   ncmp  = 0;
    int   nfail = 0;
    bit   seq[15];
    int   gi    = 0;
    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.lk = 0; m.fill = 0; m.match = 0; m.miss = 0;
        m.ecnt = 0; m.bcnt = 0; m.err = 0; m.age = 4'd0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int sync_len, int loss_len, int cmax,
                                   bit e, bit b, bit c);
        mdl_t n;
        bit   p;
        bit   nb;
        n     = m;
        n.err = 0;
        if (e) begin
            p = m.age[3] ^ m.age[2];
            if (!m.lk) begin
                nb = b;
                if (m.fill < 4) n.fill = m.fill + 1;
                else if (b == p && m.age != 4'd0) begin
                    n.match = m.match + 1;
                    if (n.match == sync_len) begin
                        n.lk   = 1;
                        n.miss = 0;
                    end
                end else n.match = 0;
            end else begin
                nb = p;
                if (m.bcnt < cmax) n.bcnt = m.bcnt + 1;
                if (b != p) begin
                    n.err  = 1;
                    n.miss = m.miss + 1;
                    if (m.ecnt < cmax) n.ecnt = m.ecnt + 1;
                    if (n.miss == loss_len) begin
                        n.lk = 0; n.fill = 0; n.match = 0; n.miss = 0;
                    end
                end else n.miss = 0;
            end
            n.age = {m.age[2:0], nb};
        end
        if (c) begin
            n.ecnt = 0;
            n.bcnt = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("a_locked", 32'(bus_a.locked), 32'(ma.lk));
        chk("a_err", 32'(bus_a.err), 32'(ma.err));
        chk("a_err_cnt", 32'(bus_a.err_cnt), ma.ecnt);
        chk("b_locked", 32'(bus_b.locked), 32'(mb.lk));
        chk("b_err", 32'(bus_b.err), 32'(mb.err));
        chk("b_err_cnt", 32'(bus_b.err_cnt), mb.ecnt);
`ifdef LFSR_CHK_BITCNT_EN
        chk("a_bit_cnt", 32'(bus_a.bit_cnt), ma.bcnt);
        chk("b_bit_cnt", 32'(bus_b.bit_cnt), mb.bcnt);
`endif
    endtask

    task automatic step_raw(input bit e, input bit b, input bit c);
        en  = e;
        d   = b;
        clr = c;
        @(posedge clk);
        ma = mstep(ma, 8, 3, 65535, e, b, c);
        mb = mstep(mb, 8, 15, 15, e, b, c);
        if (e) gi++;
        #1;
        check_all();
    endtask

    task automatic step(input bit flip, input bit c);
        step_raw(1'b1, seq[gi % 15] ^ flip, c);
    endtask

    task automatic do_reset();
        en  = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_a_locked", 32'(bus_a.locked), 0);
        chk("rst_a_err", 32'(bus_a.err), 0);
        chk("rst_a_err_cnt", 32'(bus_a.err_cnt), 0);
        chk("rst_b_err_cnt", 32'(bus_b.err_cnt), 0);
        ma = mreset();
        mb = mreset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        d     = 1'b0;
        clr   = 1'b0;
        seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 0;
        for (int n = 4; n < 15; n++) seq[n] = seq[n-3] ^ seq[n-4];
        ma = mreset();
        mb = mreset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all();

        // Clean lock: locked visible after the 12th sample
        repeat (11) step(1'b0, 1'b0);
        chk("lock_not_at_11", 32'(bus_a.locked), 0);
        step(1'b0, 1'b0);
        chk("lock_at_12", 32'(bus_a.locked), 1);
        repeat (200) step(1'b0, 1'b0);
        chk("clean_err_cnt", 32'(bus_a.err_cnt), 0);
`ifdef LFSR_CHK_BITCNT_EN
        chk("clean_bit_cnt", 32'(bus_a.bit_cnt), 200);
`endif

        // Single error
        step(1'b1, 1'b0);
        chk("single_err_pulse", 32'(bus_a.err), 1);
        step(1'b0, 1'b0);
        chk("single_err_one_cycle", 32'(bus_a.err), 0);
        repeat (30) step(1'b0, 1'b0);
        chk("single_err_cnt", 32'(bus_a.err_cnt), 1);
        chk("single_still_locked", 32'(bus_a.locked), 1);

        // Loss and relock
        step(1'b0, 1'b1);
        chk("clr_err_cnt", 32'(bus_a.err_cnt), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("loss_locked_after_2", 32'(bus_a.locked), 1);
        step(1'b1, 1'b0);
        chk("loss_err_3rd", 32'(bus_a.err), 1);
        chk("loss_unlocked", 32'(bus_a.locked), 0);
        chk("loss_err_cnt", 32'(bus_a.err_cnt), 3);
        repeat (11) step(1'b0, 1'b0);
        chk("relock_not_at_11", 32'(bus_a.locked), 0);
        step(1'b0, 1'b0);
        chk("relock_at_12", 32'(bus_a.locked), 1);

        // Randomized: gaps, garbage while idle, sporadic errors and clears
        repeat (400) begin
            if ($urandom_range(0, 3) != 0)
                step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 31) == 0));
            else
                step_raw(1'b0, 1'($urandom), 1'($urandom_range(0, 31) == 0));
        end

        // Reset mid-LOCK, then relock
        repeat (20) step(1'b0, 1'b0);
        chk("pre_reset_locked", 32'(bus_a.locked), 1);
        do_reset();
        repeat (11) step(1'b0, 1'b0);
        chk("post_reset_not_11", 32'(bus_a.locked), 0);
        step(1'b0, 1'b0);
        chk("post_reset_lock_12", 32'(bus_a.locked), 1);

        // Counter saturation on the 4-bit instance
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b0);
        end
        chk("b_sat_err_cnt", 32'(bus_b.err_cnt), 15);
        chk("a_isolated_err_cnt", 32'(bus_a.err_cnt), 20);
        step(1'b1, 1'b1);
        chk("clr_vs_err_a_err", 32'(bus_a.err), 1);
        chk("clr_vs_err_a_cnt", 32'(bus_a.err_cnt), 0);
        chk("clr_vs_err_b_cnt", 32'(bus_b.err_cnt), 0);

        // Degenerate all-zero input never locks
        do_reset();
        repeat (100) step_raw(1'b1, 1'b0, 1'b0);
        chk("zeros_never_lock", 32'(bus_a.locked), 0);

        // Gapped input: lock point counted in enabled samples
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step_raw(1'b0, 1'($urandom), 1'b0);
            step(1'b0, 1'b0);
            if (i == 10) chk("gap_not_at_11", 32'(bus_a.locked), 0);
        end
        chk("gap_lock_at_12", 32'(bus_a.locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/lfsr_chk.md
# lfsr_chk

Serial checker for the 4-bit maximal-length LFSR stream (x^4+x^3+1 style, period 15) produced by the project's LFSR generator, where each enabled generator step emits state bit 0. The block sits at the receive end of a link or loopback path. It samples one bit per enabled cycle and self-synchronises to the sequence with no seed exchange. Once locked, it counts bit errors for BER measurement and drops lock after sustained mismatches.

## Interface
- `SYNC_LEN`, default 8: consecutive correct predictions required in HUNT before entering LOCK (1..15).
- `LOSS_LEN`, default 3: consecutive mismatches in LOCK that force a return to HUNT (1..15).
- `CNT_W`, default 16: width of the saturating counters.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enb`, input, 1: sample strobe. `din` is valid only when high.
- `din`, input, 1: received sequence bit.
- `clr_cnt`, input, 1: synchronous clear of the statistics counters.
- `locked`, output, 1: high while in LOCK.
- `err`, output, 1: one-cycle pulse for each mismatched bit in LOCK.
- `err_cnt`, output, CNT_W: saturating error count.
- `bit_cnt`, output, CNT_W: saturating checked-bit count. Present only with `LFSR_CHK_BITCNT_EN`.

## Operation
- **History register `hist[3:0]`** mirrors the generator state. `hist[0]` is the oldest bit.
- **Prediction:** `pred = hist[1] ^ hist[0]`, from the recurrence b(n+4) = b(n+1) ^ b(n).
- **Shift:** `hist <= {new_bit, hist[3:1]}` on every `enb` cycle.
- **HUNT state (reset state):**
  - `new_bit = din`.
  - A fill counter counts the first 4 samples. No comparisons are made until it reaches 4.
  - After fill, a sample is a match only if `din == pred` and `hist != 0`. The all-zero history is always treated as a mismatch, so the lock-up state is never accepted.
  - A match increments `match_cnt`. A mismatch clears `match_cnt` to 0.
  - When `match_cnt` reaches `SYNC_LEN`, the state moves to LOCK on that same edge and `miss_cnt` is set to 0.
- **LOCK state:**
  - `new_bit = pred`. The reference free-runs, so an input error does not corrupt later predictions.
  - A mismatch (`din != pred`):
    - pulses `err`;
    - increments `err_cnt` (saturating at all-ones);
    - increments `miss_cnt`.
  - A match clears `miss_cnt`.
  - When `miss_cnt` reaches `LOSS_LEN`, the state moves to HUNT and the fill counter, `match_cnt` and `miss_cnt` are cleared. The mismatch that triggers the loss still pulses `err` and is counted.
- **`enb` low:** all state, history and counters hold. `err` is 0.
- **`clr_cnt`:**
  - Clears `err_cnt` (and `bit_cnt`) to 0.
  - Takes priority over a simultaneous increment. That increment is discarded, but `err` still pulses.
  - Does not affect lock state.
- **Reset values:** `locked` = 0, `err` = 0, `err_cnt` = 0, `bit_cnt` = 0, `hist` = 0, all internal counters = 0, state = HUNT.

## Timing
- All outputs are registered and appear one cycle after the `enb` edge that sampled the bit.
- `locked` rises on the clock edge of the sample that makes `match_cnt` equal `SYNC_LEN`, and is visible the following cycle.
- Minimum lock time from reset on a clean stream is 4 + `SYNC_LEN` enabled samples.
- `err` is high for exactly one cycle per erroneous sample. Back-to-back errors on consecutive enabled cycles give back-to-back pulses.
- `locked` falls in the same cycle that `err` shows the `LOSS_LEN`-th consecutive error.
- Asserting `rst_n` clears all outputs immediately, with no clock needed. Release is synchronous to `clk`, and the block resumes in HUNT.

## Configuration
- **`LFSR_CHK_BITCNT_EN` defined:**
  - Port `bit_cnt` exists.
  - It increments (saturating) on every `enb` cycle in LOCK, including error samples.
  - It is cleared by `clr_cnt` and reset. BER = `err_cnt` / `bit_cnt`.
- **Not defined:** port `bit_cnt` and its logic are absent. All other behaviour is identical.

## Test plan
- **Clean lock:** generator seeded 4'b0001, `enb` = 1 every cycle, `SYNC_LEN` = 8. `locked` = 1 after the 12th sample; `err_cnt` = 0 after 200 further bits; `bit_cnt` = 200 when the macro is defined.
- **Single error:** while locked, invert one bit. `err` pulses once, `err_cnt` = 1, `locked` stays 1, and no further errors follow.
- **Loss and relock:** while locked, invert 3 consecutive bits (`LOSS_LEN` = 3). `err_cnt` = 3 and `locked` goes to 0 with the third `err`. On a clean stream, relock occurs 12 samples later.
- **Degenerate and gapped input:**
  - `din` = 0 for 100 samples: `locked` never asserts.
  - Clean stream with `enb` alternating 1/0 and garbage on `din` while `enb` = 0: same lock point as the clean-lock test, counted in enabled samples.
- **Counter control:** `CNT_W` = 4, `LOSS_LEN` = 15, 20 isolated errors. `err_cnt` saturates at 15. `clr_cnt` coincident with an error gives `err_cnt` = 0 with `err` = 1.
- **Reset mid-LOCK:** drive `rst_n` low between clock edges. `locked`, `err` and `err_cnt` go to 0 before the next edge; after release the block relocks in 12 samples.
